// File: rtl/diffeq_host_sequencer.sv
// Host-side sequencer: runs one diffeq solve per command and returns the final x/y/u, step count and status.
// Optional step-limit timeout is compiled in with `define DIFFEQ_TIMEOUT_EN.
module diffeq_host_sequencer #(
    parameter int WIDTH     = 32,
    parameter int CNT_WIDTH = 16,
    parameter int MAX_ITER  = 1024
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [WIDTH-1:0]     cmd_a,
    input  logic [WIDTH-1:0]     cmd_dx,
    output logic                 slv_reset,
    output logic [WIDTH-1:0]     slv_aport,
    output logic [WIDTH-1:0]     slv_dxport,
    input  logic [WIDTH-1:0]     slv_x,
    input  logic [WIDTH-1:0]     slv_y,
    input  logic [WIDTH-1:0]     slv_u,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [WIDTH-1:0]     res_x,
    output logic [WIDTH-1:0]     res_y,
    output logic [WIDTH-1:0]     res_u,
    output logic [CNT_WIDTH-1:0] res_iter,
    output logic [1:0]           res_status,
    output logic                 busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_BAD_DX   = 2'b01;
    localparam logic [1:0] ST_OVERFLOW = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

    if (WIDTH < 1 || CNT_WIDTH < 1 || MAX_ITER < 1) begin : g_bad_param
        $error("diffeq_host_sequencer: WIDTH, CNT_WIDTH and MAX_ITER must be positive");
    end

    state_t               r_state;
    logic [WIDTH-1:0]     r_a;
    logic [WIDTH-1:0]     r_dx;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_clear;
    logic [WIDTH-1:0]     r_res_x;
    logic [WIDTH-1:0]     r_res_y;
    logic [WIDTH-1:0]     r_res_u;
    logic [CNT_WIDTH-1:0] r_res_iter;
    logic [1:0]           r_res_status;

    logic w_reached;
    logic w_carry;
    logic w_timeout;
    logic w_cnt_full;

    assign w_reached  = (slv_x >= r_a);
    // x + dx carries out exactly when x exceeds the bitwise complement of dx.
    assign w_carry    = (slv_x > ~r_dx);
    assign w_cnt_full = &r_cnt;

`ifdef DIFFEQ_TIMEOUT_EN
    localparam logic [CNT_WIDTH-1:0] MAX_CNT = CNT_WIDTH'(MAX_ITER);

    if (MAX_ITER >= (64'd1 << CNT_WIDTH)) begin : g_bad_max_iter
        $error("diffeq_host_sequencer: MAX_ITER does not fit in CNT_WIDTH bits");
    end

    assign w_timeout = (r_cnt == MAX_CNT);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_a          <= '0;
            r_dx         <= '0;
            r_cnt        <= '0;
            r_clear      <= 1'b0;
            r_res_x      <= '0;
            r_res_y      <= '0;
            r_res_u      <= '0;
            r_res_iter   <= '0;
            r_res_status <= ST_OK;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_a   <= cmd_a;
                        r_dx  <= cmd_dx;
                        r_cnt <= '0;
                        // A zero step with a nonzero limit would never finish.
                        if (cmd_dx == '0 && cmd_a != '0) begin
                            r_state      <= S_DONE;
                            r_res_x      <= '0;
                            r_res_y      <= '0;
                            r_res_u      <= '0;
                            r_res_iter   <= '0;
                            r_res_status <= ST_BAD_DX;
                        end else begin
                            r_state <= S_CLEAR;
                            r_clear <= 1'b1;
                        end
                    end
                end

                S_CLEAR: begin
                    r_clear <= 1'b0;
                    r_state <= S_RUN;
                end

                S_RUN: begin
                    if (w_reached || w_carry || w_timeout) begin
                        r_state    <= S_DONE;
                        r_res_x    <= slv_x;
                        r_res_y    <= slv_y;
                        r_res_u    <= slv_u;
                        r_res_iter <= r_cnt;
                        if (w_reached) begin
                            r_res_status <= ST_OK;
                        end else if (w_carry) begin
                            r_res_status <= ST_OVERFLOW;
                        end else begin
                            r_res_status <= ST_TIMEOUT;
                        end
                    end else if (!w_cnt_full) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                S_DONE: begin
                    if (res_ready) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The solver is held in reset alongside the host, and pulsed once per solve.
    assign slv_reset  = reset | r_clear;
    assign slv_aport  = r_a;
    assign slv_dxport = r_dx;

    assign cmd_ready  = (r_state == S_IDLE);
    assign res_valid  = (r_state == S_DONE);
    assign busy       = (r_state != S_IDLE);

    assign res_x      = r_res_x;
    assign res_y      = r_res_y;
    assign res_u      = r_res_u;
    assign res_iter   = r_res_iter;
    assign res_status = r_res_status;

endmodule

// File: tb/tb_diffeq_host_sequencer.sv
// Directed bench for diffeq_host_sequencer with a behavioural diffeq solver attached.
module tb_diffeq_host_sequencer;

    localparam int W  = 32;
    localparam int CW = 8;
`ifdef DIFFEQ_TIMEOUT_EN
    localparam int MI = 16;
`else
    localparam int MI = 1024;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [W-1:0]  cmd_a = '0;
    logic [W-1:0]  cmd_dx = '0;
    logic          slv_reset;
    logic [W-1:0]  slv_aport;
    logic [W-1:0]  slv_dxport;
    logic [W-1:0]  sx = '0;
    logic [W-1:0]  sy = '0;
    logic [W-1:0]  su = '0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [W-1:0]  res_x;
    logic [W-1:0]  res_y;
    logic [W-1:0]  res_u;
    logic [CW-1:0] res_iter;
    logic [1:0]    res_status;
    logic          busy;

    int total = 0;
    int bad = 0;

    diffeq_host_sequencer #(.WIDTH(W), .CNT_WIDTH(CW), .MAX_ITER(MI)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_dx(cmd_dx),
        .slv_reset(slv_reset), .slv_aport(slv_aport), .slv_dxport(slv_dxport),
        .slv_x(sx), .slv_y(sy), .slv_u(su),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_x(res_x), .res_y(res_y), .res_u(res_u),
        .res_iter(res_iter), .res_status(res_status), .busy(busy)
    );

    always #5 clk = ~clk;

    // Classic diffeq solver step: x += dx; u -= 3xu*dx + 3y*dx; y += u*dx.
    always @(posedge clk) begin
        if (slv_reset) begin
            sx <= '0;
            sy <= '0;
            su <= '0;
        end else begin
            sx <= sx + slv_dxport;
            su <= su - W'(3) * sx * su * slv_dxport - W'(3) * sy * slv_dxport;
            sy <= sy + su * slv_dxport;
        end
    end

    // Drives one command, then counts edges until res_valid and solver-reset samples on the way.
    task automatic run_cmd(input logic [W-1:0] a, input logic [W-1:0] dx,
                           output int lat, output int pulses, output bit expired);
        @(negedge clk);
        cmd_a = a;
        cmd_dx = dx;
        cmd_valid = 1'b1;
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_a = 32'hA5A5_A5A5;
        cmd_dx = 32'h5A5A_5A5A;
        lat = 0;
        pulses = 0;
        expired = 1'b0;
        while (!res_valid && !expired) begin
            if (slv_reset) pulses++;
            @(posedge clk);
            #1;
            lat++;
            if (lat > 600) expired = 1'b1;
        end
        if (slv_reset) pulses++;
    endtask

    task automatic release_result();
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        total++;
        if ({slv_reset, busy, res_valid, cmd_ready} !== 4'b1001) begin
            bad++;
            $display("FAIL reset_ctrl: got slv_reset/busy/res_valid/cmd_ready=%b want 1001",
                     {slv_reset, busy, res_valid, cmd_ready});
        end
        total++;
        if ({res_x, res_y, res_u, res_iter, res_status} !== '0) begin
            bad++;
            $display("FAIL reset_res: got x=%h y=%h u=%h iter=%0d st=%b want all zero",
                     res_x, res_y, res_u, res_iter, res_status);
        end
        total++;
        if ({slv_aport, slv_dxport} !== '0) begin
            bad++;
            $display("FAIL reset_ports: got aport=%h dxport=%h want 0", slv_aport, slv_dxport);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (slv_reset !== 1'b0) begin
            bad++;
            $display("FAIL reset_release: got slv_reset=%b want 0", slv_reset);
        end
    endtask

    task automatic test_zero_limit();
        int lat, pulses;
        bit expired;
        run_cmd(32'd0, 32'd1, lat, pulses, expired);
        total++;
        if (expired || lat != 2) begin
            bad++;
            $display("FAIL zero_limit_latency: got %0d (expired=%0d) want 2", lat, expired);
        end
        total++;
        if (pulses != 1) begin
            bad++;
            $display("FAIL zero_limit_pulses: got %0d want 1", pulses);
        end
        total++;
        if ({res_x, res_y, res_u, res_iter, res_status} !== '0) begin
            bad++;
            $display("FAIL zero_limit_result: got x=%h y=%h u=%h iter=%0d st=%b want all zero",
                     res_x, res_y, res_u, res_iter, res_status);
        end
        total++;
        if ({slv_aport, slv_dxport} !== {32'd0, 32'd1}) begin
            bad++;
            $display("FAIL zero_limit_ports: got aport=%h dxport=%h want 0/1", slv_aport, slv_dxport);
        end
        release_result();
        total++;
        if ({res_valid, cmd_ready, busy} !== 3'b010) begin
            bad++;
            $display("FAIL zero_limit_release: got valid/ready/busy=%b want 010",
                     {res_valid, cmd_ready, busy});
        end
    endtask

    task automatic test_step_and_hold();
        int lat, pulses;
        bit expired;
        run_cmd(32'd5, 32'd2, lat, pulses, expired);
        total++;
        if (expired || lat != 5) begin
            bad++;
            $display("FAIL step_latency: got %0d (expired=%0d) want 5", lat, expired);
        end
        total++;
        if ({res_x, res_y, res_u, res_iter, res_status} !== {32'd6, 32'd0, 32'd0, 8'd3, 2'b00}) begin
            bad++;
            $display("FAIL step_result: got x=%0d y=%0d u=%0d iter=%0d st=%b want 6/0/0/3/00",
                     res_x, res_y, res_u, res_iter, res_status);
        end
        total++;
        if (pulses != 1 || slv_aport !== 32'd5 || slv_dxport !== 32'd2) begin
            bad++;
            $display("FAIL step_ports: got pulses=%0d aport=%0d dxport=%0d want 1/5/2",
                     pulses, slv_aport, slv_dxport);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            total++;
            if ({res_valid, cmd_ready, res_x, res_iter, res_status} !== {1'b1, 1'b0, 32'd6, 8'd3, 2'b00}) begin
                bad++;
                $display("FAIL step_hold[%0d]: got valid=%b ready=%b x=%0d iter=%0d st=%b want 1/0/6/3/00",
                         i, res_valid, cmd_ready, res_x, res_iter, res_status);
            end
        end
        release_result();
        total++;
        if (res_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            bad++;
            $display("FAIL step_release: got valid=%b ready=%b want 0/1", res_valid, cmd_ready);
        end
    endtask

    task automatic test_bad_dx();
        int lat, pulses;
        bit expired;
        run_cmd(32'd5, 32'd0, lat, pulses, expired);
        // Result is already valid in the first cycle following the accept.
        total++;
        if (expired || lat != 0) begin
            bad++;
            $display("FAIL bad_dx_latency: got %0d extra edges want 0", lat);
        end
        total++;
        if ({res_x, res_iter, res_status} !== {32'd0, 8'd0, 2'b01} || pulses != 0) begin
            bad++;
            $display("FAIL bad_dx_result: got x=%0d iter=%0d st=%b pulses=%0d want 0/0/01/0",
                     res_x, res_iter, res_status, pulses);
        end
        release_result();
        run_cmd(32'd0, 32'd0, lat, pulses, expired);
        total++;
        if (expired || lat != 2 || res_status !== 2'b00 || pulses != 1) begin
            bad++;
            $display("FAIL zero_both: got lat=%0d st=%b pulses=%0d want 2/00/1", lat, res_status, pulses);
        end
        release_result();
    endtask

    task automatic test_overflow();
        int lat, pulses;
        bit expired;
        run_cmd(32'hFFFF_FFFF, 32'h8000_0000, lat, pulses, expired);
        total++;
        if (expired || lat != 3) begin
            bad++;
            $display("FAIL overflow_latency: got %0d want 3", lat);
        end
        total++;
        if ({res_x, res_iter, res_status} !== {32'h8000_0000, 8'd1, 2'b10}) begin
            bad++;
            $display("FAIL overflow_result: got x=%h iter=%0d st=%b want 80000000/1/10",
                     res_x, res_iter, res_status);
        end
        release_result();
    endtask

`ifdef DIFFEQ_TIMEOUT_EN
    task automatic test_timeout();
        int lat, pulses;
        bit expired;
        run_cmd(32'd1000, 32'd1, lat, pulses, expired);
        total++;
        if (expired || lat != 18) begin
            bad++;
            $display("FAIL timeout_latency: got %0d want 18", lat);
        end
        total++;
        if ({res_x, res_iter, res_status} !== {32'd16, 8'd16, 2'b11}) begin
            bad++;
            $display("FAIL timeout_result: got x=%0d iter=%0d st=%b want 16/16/11",
                     res_x, res_iter, res_status);
        end
        release_result();
    endtask
`else
    task automatic test_saturation();
        int lat, pulses;
        bit expired;
        run_cmd(32'd300, 32'd1, lat, pulses, expired);
        total++;
        if (expired || lat != 302) begin
            bad++;
            $display("FAIL saturate_latency: got %0d want 302", lat);
        end
        total++;
        if ({res_x, res_iter, res_status} !== {32'd300, 8'd255, 2'b00}) begin
            bad++;
            $display("FAIL saturate_result: got x=%0d iter=%0d st=%b want 300/255/00",
                     res_x, res_iter, res_status);
        end
        release_result();
    endtask
`endif

    task automatic test_back_to_back();
        int lat, pulses;
        bit expired;
        run_cmd(32'd3, 32'd3, lat, pulses, expired);
        total++;
        if (expired || lat != 3 || {res_x, res_iter, res_status} !== {32'd3, 8'd1, 2'b00}) begin
            bad++;
            $display("FAIL b2b_first: got lat=%0d x=%0d iter=%0d st=%b want 3/3/1/00",
                     lat, res_x, res_iter, res_status);
        end
        release_result();
        run_cmd(32'd7, 32'd4, lat, pulses, expired);
        total++;
        if (expired || lat != 4 || {res_x, res_iter, res_status} !== {32'd8, 8'd2, 2'b00}) begin
            bad++;
            $display("FAIL b2b_second: got lat=%0d x=%0d iter=%0d st=%b want 4/8/2/00",
                     lat, res_x, res_iter, res_status);
        end
        release_result();
    endtask

    task automatic test_reset_mid_run();
        int lat, pulses;
        bit expired;
        @(negedge clk);
        cmd_a = 32'd100;
        cmd_dx = 32'd1;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if ({busy, res_valid} !== 2'b10) begin
            bad++;
            $display("FAIL midrun_busy: got busy/valid=%b want 10", {busy, res_valid});
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if ({busy, res_valid, cmd_ready, slv_reset} !== 4'b0011 || res_x !== '0) begin
            bad++;
            $display("FAIL midrun_reset: got busy/valid/ready/slv_reset=%b x=%0d want 0011/0",
                     {busy, res_valid, cmd_ready, slv_reset}, res_x);
        end
        @(negedge clk);
        reset = 1'b0;
        run_cmd(32'd2, 32'd1, lat, pulses, expired);
        total++;
        if (expired || lat != 4 || {res_x, res_iter, res_status} !== {32'd2, 8'd2, 2'b00}) begin
            bad++;
            $display("FAIL midrun_next: got lat=%0d x=%0d iter=%0d st=%b want 4/2/2/00",
                     lat, res_x, res_iter, res_status);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_zero_limit();
        test_step_and_hold();
        test_bad_dx();
        test_overflow();
`ifdef DIFFEQ_TIMEOUT_EN
        test_timeout();
`else
        test_saturation();
`endif
        test_back_to_back();
        test_reset_mid_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
